// File: rtl/spi_responder_pkg.sv
// Shared types and defaults for the SPI mode-0 responder.
package spi_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LAST  = 2'd2
   } state_e;

   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_SYNC_STAGES  = 2;
   localparam int DEF_IDLE_TIMEOUT = 64;

   // bit_cnt must be able to hold the value DataWidth itself
   function automatic int cnt_width(input int data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

// File: rtl/spi_responder_sync.sv
// Multi-flop synchronizer with optional registered rise/fall pulse detection.
module spi_responder_sync
   import spi_responder_pkg::*;
#(
   parameter int Stages     = DEF_SYNC_STAGES,
   parameter bit EdgeDetect = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [Stages-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[Stages-2:0], din};
      end
   end

   assign dout = chain[Stages-1];

   if (EdgeDetect) begin : g_edge
      logic prev;
      logic rise_q;
      logic fall_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            prev   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            prev   <= dout;
            rise_q <= dout & ~prev;
            fall_q <= ~dout & prev;
         end
      end

      assign rise = rise_q;
      assign fall = fall_q;
   end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
   end

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 device-side responder: oversampled SCK/SDI, bit-count framing
// with idle-timeout abort, single-entry transmit holding register.
module spi_responder
   import spi_responder_pkg::*;
#(
   parameter int                   DataWidth   = DEF_DATA_WIDTH,
   parameter int                   SyncStages  = DEF_SYNC_STAGES,
   parameter int                   IdleTimeout = DEF_IDLE_TIMEOUT,
   parameter logic [DataWidth-1:0] IdleWord    = '1
) (
   input  logic                 clk_sys_i,
   input  logic                 rst_sys_ni,
   input  logic                 spi_sck_i,
   input  logic                 spi_sdi_i,
   output logic                 spi_sdo_o,
   input  logic [DataWidth-1:0] tx_data_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic [DataWidth-1:0] rx_data_o,
   output logic                 rx_valid_o,
   output logic                 frame_err_o
);

   localparam int              CntW    = cnt_width(DataWidth);
   localparam int              TmoW    = $clog2(IdleTimeout + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(DataWidth - 1);
   localparam logic [TmoW-1:0] TmoMax  = TmoW'(IdleTimeout);

   logic sck_rise;
   logic sck_fall;
   logic sck_level;
   logic sdi;

   spi_responder_sync #(
      .Stages     (SyncStages),
      .EdgeDetect (1'b1)
   ) u_sync_sck (
      .clk   (clk_sys_i),
      .rst_n (rst_sys_ni),
      .din   (spi_sck_i),
      .dout  (sck_level),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   spi_responder_sync #(
      .Stages     (SyncStages),
      .EdgeDetect (1'b0)
   ) u_sync_sdi (
      .clk   (clk_sys_i),
      .rst_n (rst_sys_ni),
      .din   (spi_sdi_i),
      .dout  (sdi),
      .rise  (),
      .fall  ()
   );

   state_e               state;
   logic [CntW-1:0]      bit_cnt;
   logic [TmoW-1:0]      idle_cnt;
   logic [DataWidth-1:0] tx_sr;
   logic [DataWidth-1:0] rx_sr;
   logic [DataWidth-1:0] tx_hold;
   logic                 hold_valid;
   logic [DataWidth-1:0] rx_data;
   logic                 rx_valid;
   logic                 frame_err;
   logic [DataWidth-1:0] rx_next;
   logic                 sck_edge;

   assign rx_next  = {rx_sr[DataWidth-2:0], sdi};
   assign sck_edge = sck_rise | sck_fall;

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         idle_cnt   <= '0;
         tx_sr      <= IdleWord;
         rx_sr      <= '0;
         tx_hold    <= '0;
         hold_valid <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;

         // A same-cycle accept lands in tx_hold for the following word,
         // since hold_valid can only be set here while it is still clear.
         if (tx_valid_i && !hold_valid) begin
            tx_hold    <= tx_data_i;
            hold_valid <= 1'b1;
         end

         if (sck_edge || state == ST_IDLE) begin
            idle_cnt <= '0;
         end else if (idle_cnt != TmoMax) begin
            idle_cnt <= idle_cnt + TmoW'(1);
         end

         case (state)
            ST_IDLE: begin
               tx_sr <= hold_valid ? tx_hold : IdleWord;
               if (sck_rise) begin
                  rx_sr <= {{(DataWidth-1){1'b0}}, sdi};
                  if (hold_valid) begin
                     hold_valid <= 1'b0;
                  end
                  bit_cnt <= CntW'(1);
                  state   <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               if (sck_fall) begin
                  tx_sr <= {tx_sr[DataWidth-2:0], 1'b0};
               end
               if (sck_rise) begin
                  rx_sr   <= rx_next;
                  bit_cnt <= bit_cnt + CntW'(1);
                  if (bit_cnt == LastCnt) begin
                     state    <= ST_LAST;
                     rx_data  <= rx_next;
                     rx_valid <= 1'b1;
                  end
               end else if (!sck_fall && idle_cnt == TmoMax) begin
                  state     <= ST_IDLE;
                  bit_cnt   <= '0;
                  rx_sr     <= '0;
                  frame_err <= 1'b1;
               end
            end

            ST_LAST: begin
               // The word was already delivered, so a timeout here is silent.
               if (sck_fall || (!sck_rise && idle_cnt == TmoMax)) begin
                  state   <= ST_IDLE;
                  bit_cnt <= '0;
               end
            end

            default: begin
               state   <= ST_IDLE;
               bit_cnt <= '0;
            end
         endcase
      end
   end

   assign spi_sdo_o   = tx_sr[DataWidth-1];
   assign tx_ready_o  = ~hold_valid;
   assign rx_data_o   = rx_data;
   assign rx_valid_o  = rx_valid;
   assign frame_err_o = frame_err;

endmodule

// File: tb/tb_spi_responder.sv
// Randomized self-checking bench: a bit-level SPI host plus a word-level
// queue model of what the responder must return and deliver.
module tb_spi_responder;

   localparam int SYNC = 2;
   localparam int TMO  = 64;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       sck      = 1'b0;
   logic       sdi      = 1'b0;
   logic       sdo;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;

   int checks        = 0;
   int errors        = 0;
   int cyc           = 0;
   int rx_cnt        = 0;
   int ferr_cnt      = 0;
   int last_rise_cyc = 0;
   int last_rx_cyc   = 0;

   logic [7:0] exp_rx[$];

   always #5 clk = ~clk;

   spi_responder dut (
      .clk_sys_i   (clk),
      .rst_sys_ni  (rst_n),
      .spi_sck_i   (sck),
      .spi_sdi_i   (sdi),
      .spi_sdo_o   (sdo),
      .tx_data_i   (tx_data),
      .tx_valid_i  (tx_valid),
      .tx_ready_o  (tx_ready),
      .rx_data_o   (rx_data),
      .rx_valid_o  (rx_valid),
      .frame_err_o (frame_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Receive-side scoreboard: every rx_valid cycle must match the next word sent.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin
            rx_cnt++;
            last_rx_cyc = cyc;
            if (exp_rx.size() > 0) check("rx_data", rx_data, exp_rx.pop_front());
            else check("rx_unexpected", rx_valid, 1'b0);
         end
         if (frame_err) ferr_cnt++;
      end
   end

   task automatic queue_tx(input logic [7:0] v);
      int n = 0;
      while (!tx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("tx_ready_wait", tx_ready, 1'b1);
      tx_data  = v;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("tx_ready_full", tx_ready, 1'b0);
   endtask

   // Mode-0 host: drive MOSI while SCK low, sample MISO at the rising edge.
   task automatic xfer(input logic [7:0] mosi, input int nbits, input int hp,
                       input bit mid_q, input logic [7:0] mid_val,
                       input bit same_q, input logic [7:0] same_val,
                       output logic [7:0] miso);
      miso = 8'h00;
      if (nbits == 8) exp_rx.push_back(mosi);
      for (int b = 0; b < nbits; b++) begin
         sdi = mosi[7-b];
         repeat (hp) @(negedge clk);
         sck  = 1'b1;
         miso = {miso[6:0], sdo};
         last_rise_cyc = cyc;
         if (b == 0 && same_q) begin
            repeat (SYNC + 1) @(negedge clk);
            tx_data  = same_val;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (hp - SYNC - 2) @(negedge clk);
         end else begin
            repeat (hp) @(negedge clk);
         end
         sck = 1'b0;
         if (b == 0 && mid_q) queue_tx(mid_val);
      end
      repeat (hp) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] miso;
      logic [7:0] v;
      logic [7:0] m;
      int         hp;
      bit         q;
      int         r0;
      int         f0;
      int         lat;

      repeat (3) @(negedge clk);
      check("reset_sdo", sdo, 1'b1);
      check("reset_tx_ready", tx_ready, 1'b1);
      check("reset_rx_valid", rx_valid, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_rx_data", rx_data, 8'h00);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Basic transfer
      queue_tx(8'h3C);
      r0 = rx_cnt;
      xfer(8'hA5, 8, 8, 1'b0, 8'h00, 1'b0, 8'h00, miso);
      lat = last_rx_cyc - last_rise_cyc;
      check("basic_miso", miso, 8'h3C);
      check("basic_rx_cnt", rx_cnt - r0, 1);
      check("basic_rx_data", rx_data, 8'hA5);
      check("basic_latency_ok", (lat >= SYNC + 1 && lat <= SYNC + 2), 1'b1);
      check("basic_ready_after", tx_ready, 1'b1);

      // Empty queue
      xfer(8'h12, 8, 8, 1'b0, 8'h00, 1'b0, 8'h00, miso);
      check("empty_miso", miso, 8'hFF);
      check("empty_rx_data", rx_data, 8'h12);

      // Back to back, second word queued during the first
      queue_tx(8'h55);
      r0 = rx_cnt;
      xfer(8'h01, 8, 8, 1'b1, 8'hAA, 1'b0, 8'h00, miso);
      check("b2b_miso0", miso, 8'h55);
      xfer(8'h80, 8, 8, 1'b0, 8'h00, 1'b0, 8'h00, miso);
      check("b2b_miso1", miso, 8'hAA);
      check("b2b_rx_cnt", rx_cnt - r0, 2);

      // Timeout abort of a 3-bit partial word
      r0 = rx_cnt;
      f0 = ferr_cnt;
      xfer(8'hE0, 3, 8, 1'b0, 8'h00, 1'b0, 8'h00, miso);
      repeat (TMO + 20) @(negedge clk);
      check("tmo_frame_err_cnt", ferr_cnt - f0, 1);
      check("tmo_rx_cnt", rx_cnt - r0, 0);
      xfer(8'h5A, 8, 8, 1'b0, 8'h00, 1'b0, 8'h00, miso);
      check("tmo_next_rx_data", rx_data, 8'h5A);
      check("tmo_next_miso", miso, 8'hFF);
      check("tmo_next_rx_cnt", rx_cnt - r0, 1);

      // Accept in the same cycle as the first synchronized rise
      xfer(8'h33, 8, 8, 1'b0, 8'h00, 1'b1, 8'h77, miso);
      check("same_miso0", miso, 8'hFF);
      check("same_ready_mid", tx_ready, 1'b0);
      xfer(8'hC3, 8, 8, 1'b0, 8'h00, 1'b0, 8'h00, miso);
      check("same_miso1", miso, 8'h77);

      // Randomized words, random queueing and half-period
      for (int i = 0; i < 16; i++) begin
         q  = 1'($urandom_range(0, 1));
         v  = 8'($urandom);
         m  = 8'($urandom);
         hp = $urandom_range(SYNC + 4, 12);
         if (q) queue_tx(v);
         xfer(m, 8, hp, 1'b0, 8'h00, 1'b0, 8'h00, miso);
         check("rand_miso", miso, q ? v : 8'hFF);
         check("rand_rx_data", rx_data, m);
         check("rand_ready", tx_ready, 1'b1);
      end
      check("rx_pending", exp_rx.size(), 0);

      // Reset in the middle of a word
      queue_tx(8'h99);
      xfer(8'hF0, 4, 8, 1'b0, 8'h00, 1'b0, 8'h00, miso);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_sdo", sdo, 1'b1);
      check("midrst_tx_ready", tx_ready, 1'b1);
      check("midrst_rx_valid", rx_valid, 1'b0);
      check("midrst_frame_err", frame_err, 1'b0);
      check("midrst_rx_data", rx_data, 8'h00);
      rst_n = 1'b1;
      r0 = rx_cnt;
      f0 = ferr_cnt;
      repeat (TMO + 30) @(negedge clk);
      check("midrst_no_frame_err", ferr_cnt - f0, 0);
      check("midrst_no_rx", rx_cnt - r0, 0);
      xfer(8'h6B, 8, 8, 1'b0, 8'h00, 1'b0, 8'h00, miso);
      check("midrst_next_miso", miso, 8'hFF);
      check("midrst_next_rx_data", rx_data, 8'h6B);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
